// File: rtl/bus_b_pkg.sv
// Shared definitions for the bus B arbitration slice.
//   - src_e      : 3-bit bus B source multiplexer codes.
//   - arb_state_e: bus_b_arbiter FSM states.
//   - clog2_min1 : counter width helper that never returns zero.
package bus_b_pkg;

    typedef enum logic [2:0] {
        SRC_RAM   = 3'd0,
        SRC_PC    = 3'd1,
        SRC_R1    = 3'd2,
        SRC_R2    = 3'd3,
        SRC_TR    = 3'd4,
        SRC_R     = 3'd5,
        SRC_AC    = 3'd6,
        SRC_INSTR = 3'd7
    } src_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    : request vector, one bit per requester.
//   ptr    : first index to consider; search wraps modulo NUM_REQ.
//   winner : index of the first requesting bit at or after ptr.
//   any    : high when at least one request is present.
module rr_pick #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    int unsigned   idx;
    logic [IW-1:0] cand;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // ptr < NUM_REQ and k < NUM_REQ, so one subtraction wraps it.
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IW'(idx);
            if (!any && req[cand]) begin
                winner = cand;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_b_arbiter.sv
// Round-robin owner arbitration for the shared 16-bit bus B source mux.
// Grants one requester at a time, latches its source code onto SELECT for
// the whole tenure, bounds the tenure while others wait, and inserts a
// one-cycle turnaround between owners.
// Ports:
//   CLOCK     : clock, all state changes on the rising edge.
//   RESET     : synchronous active-high reset.
//   REQ       : per-requester request level.
//   SRC_SEL   : per-requester source code, requester i on [3i+2:3i].
//   GNT       : registered one-hot grant.
//   SELECT    : registered bus B mux select.
//   BUS_VALID : high while the bus is owned.
//   OWNER     : index of the current or last owner.
// Build option: define BUS_B_PRIO0_EN to give requester 0 absolute IDLE
// priority (pointer untouched by its wins) and an unpreemptable tenure.
module bus_b_arbiter
    import bus_b_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic [NUM_REQ-1:0]           REQ,
    input  logic [3*NUM_REQ-1:0]         SRC_SEL,
    output logic [NUM_REQ-1:0]           GNT,
    output logic [2:0]                   SELECT,
    output logic                         BUS_VALID,
    output logic [$clog2(NUM_REQ)-1:0]   OWNER
);

    localparam int unsigned   IW       = $clog2(NUM_REQ);
    localparam int unsigned   HW       = clog2_min1(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [2:0]          sel_q, sel_d;
    logic                valid_q, valid_d;
    logic [IW-1:0]       owner_q, owner_d;

    logic [IW-1:0]       rr_win;
    logic                rr_any;
    logic [IW-1:0]       win;
    logic                win_any;
    logic                prio_win;
    logic [2:0]          win_src;
    logic                owner_req;
    logic                others_req;
    logic                preempt;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (REQ),
        .ptr    (ptr_q),
        .winner (rr_win),
        .any    (rr_any)
    );

    // Winner selection, including the optional requester-0 override.
    always_comb begin
        win      = rr_win;
        win_any  = rr_any;
        prio_win = 1'b0;
`ifdef BUS_B_PRIO0_EN
        if (REQ[0]) begin
            win      = '0;
            prio_win = 1'b1;
        end
`endif
        win_src = SRC_RAM;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win == IW'(i)) begin
                win_src = SRC_SEL[3*i +: 3];
            end
        end
    end

    // In GRANT gnt_q is the owner's one-hot, so it splits REQ into the
    // owner's level and everyone else's.
    always_comb begin
        owner_req  = |(REQ & gnt_q);
        others_req = |(REQ & ~gnt_q);
        preempt    = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && others_req;
`ifdef BUS_B_PRIO0_EN
        if (owner_q == '0) begin
            preempt = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = GRANT;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        gnt_d[i] = (win == IW'(i));
                    end
                    owner_d = win;
                    sel_d   = win_src;
                    valid_d = 1'b1;
                    hold_d  = HW'(1);
                    if (!prio_win) begin
                        ptr_d = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    end
                end
            end
            GRANT: begin
                // Release and expiry both end the tenure the same way.
                if (!owner_req || preempt) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end else if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            sel_q   <= SRC_RAM;
            valid_q <= 1'b0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    assign GNT       = gnt_q;
    assign SELECT    = sel_q;
    assign BUS_VALID = valid_q;
    assign OWNER     = owner_q;

endmodule

// File: tb/tb_bus_b_arbiter.sv
// Bench for bus_b_arbiter (NUM_REQ=3, MAX_HOLD=4): directed scenarios plus
// randomized traffic, every cycle compared against a tenure-level model.
module tb_bus_b_arbiter;

    localparam int NREQ = 3;
    localparam int MH   = 4;

    logic            CLOCK = 1'b0;
    logic            RESET;
    logic [NREQ-1:0] REQ;
    logic [3*NREQ-1:0] SRC_SEL;
    logic [NREQ-1:0] GNT;
    logic [2:0]      SELECT;
    logic            BUS_VALID;
    logic [1:0]      OWNER;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who owns the bus, how long they have held it, and the
    // rotation start point.
    bit m_busy, m_turn;
    int m_owner, m_ten, m_ptr;
    int m_sel;

    int rem [NREQ];

    bus_b_arbiter #(.NUM_REQ(NREQ), .MAX_HOLD(MH)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .REQ       (REQ),
        .SRC_SEL   (SRC_SEL),
        .GNT       (GNT),
        .SELECT    (SELECT),
        .BUS_VALID (BUS_VALID),
        .OWNER     (OWNER)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit prio_owner(input int o);
`ifdef BUS_B_PRIO0_EN
        return o == 0;
`else
        return 1'b0 && (o == 0);
`endif
    endfunction

    task automatic model_edge();
        bit others;
        int w;
        if (RESET) begin
            m_busy = 0; m_turn = 0; m_owner = 0; m_ten = 0; m_ptr = 0; m_sel = 0;
        end else if (m_turn) begin
            m_turn = 0;
        end else if (m_busy) begin
            others = 0;
            for (int j = 0; j < NREQ; j++) if (j != m_owner && REQ[j]) others = 1;
            if (!REQ[m_owner] || (MH != 0 && m_ten >= MH && others && !prio_owner(m_owner))) begin
                m_busy = 0;
                m_turn = 1;
            end else begin
                m_ten++;
            end
        end else begin
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && REQ[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
`ifdef BUS_B_PRIO0_EN
            if (REQ[0]) begin
                m_busy = 1; m_owner = 0; m_ten = 1; m_sel = int'(SRC_SEL[2:0]);
                w = -1;
            end
`endif
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_ten = 1;
                m_sel = int'(SRC_SEL[3*w +: 3]);
                m_ptr = (w + 1) % NREQ;
            end
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        model_edge();
        #1;
        check("gnt",   32'(GNT),       m_busy ? (32'd1 << m_owner) : 32'd0);
        check("sel",   32'(SELECT),    32'(m_sel));
        check("valid", 32'(BUS_VALID), 32'(m_busy));
        check("owner", 32'(OWNER),     32'(m_owner));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        RESET   = 1'b1;
        REQ     = 3'b111;
        SRC_SEL = {3'd3, 3'd2, 3'd1};

        // Reset held with all requests up.
        steps(3);
        check("rst_gnt",   32'(GNT),       32'd0);
        check("rst_sel",   32'(SELECT),    32'd0);
        check("rst_valid", 32'(BUS_VALID), 32'd0);
        RESET = 1'b0;
        step();
        check("first_gnt", 32'(GNT),    32'b001);
        check("first_sel", 32'(SELECT), 32'd1);

        // Continuous contention: rotation with 4-cycle tenures.
        steps(4);
        check("rot_turn", 32'(GNT), 32'd0);
        steps(2);
`ifdef BUS_B_PRIO0_EN
        check("rot_next", 32'(GNT), 32'b001);
`else
        check("rot_next",     32'(GNT),    32'b010);
        check("rot_next_sel", 32'(SELECT), 32'd2);
`endif
        steps(24);

        // Short tenure by requester 1 with code AC.
        RESET = 1'b1; REQ = '0; step();
        RESET = 1'b0; REQ = 3'b010; SRC_SEL = {3'd3, 3'd6, 3'd1};
        step();
        check("r1_gnt", 32'(GNT),    32'b010);
        check("r1_sel", 32'(SELECT), 32'd6);
        SRC_SEL = {3'd3, 3'd0, 3'd1};
        step();
        check("r1_sel_held", 32'(SELECT), 32'd6);
        REQ = '0;
        steps(3);
        check("r1_idle", 32'(BUS_VALID), 32'd0);

        // Lone requester 2: no preemption without competition.
        REQ = 3'b100;
        step();
        for (int i = 0; i < 9; i++) begin
            step();
            check("r2_long", 32'(GNT), 32'b100);
        end
        REQ = '0;
        steps(3);

        // Reset in the second cycle of a tenure.
        RESET = 1'b1; step(); RESET = 1'b0;
        REQ = 3'b001; step(); step();
        RESET = 1'b1; step();
        check("mid_rst_gnt",   32'(GNT),       32'd0);
        check("mid_rst_owner", 32'(OWNER),     32'd0);
        check("mid_rst_valid", 32'(BUS_VALID), 32'd0);
        RESET = 1'b0; REQ = '0; step();

        // Pointer at 1, then requesters 1, 2 and 0 compete.
        REQ = 3'b001; step();
        REQ = '0; steps(3);
        REQ = 3'b111; step();
`ifdef BUS_B_PRIO0_EN
        check("prio_gnt", 32'(GNT), 32'b001);
        steps(6);
        check("prio_hold", 32'(GNT), 32'b001);
`else
        check("ptr_gnt", 32'(GNT), 32'b010);
`endif
        REQ = '0; steps(3);

        // Randomized traffic with bursty request levels and occasional reset.
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 9);
                REQ[i] = (rem[i] != 0);
                if (rem[i] != 0) rem[i]--;
            end
            SRC_SEL = 9'($urandom);
            RESET   = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
